// File: rtl/prbs_frame_checker.sv
// prbs_frame_checker
//   Serial frame checker for the end of the generator/receptor chain. It hunts
//   for the WIDTH-bit SYNC word in the one-bit-per-cycle stream, confirms
//   alignment over CONFIRM_N further frames, then checks every frame while
//   locked and keeps saturating error counters.
//
//   Optional feature macro: BIT_ERR_CNT_EN
//     When defined, adds bit_err_cnt, which accumulates the number of wrong
//     bits in each bad frame seen while locked.
//
//   Ports
//     CLK           system clock, rising edge
//     RST_N         asynchronous reset, active low
//     signal_in     serial bit from the receptor, sampled every cycle
//     clr_cnt       synchronous clear of the error counters
//     locked        high while in LOCKED
//     frame_valid   one-cycle pulse at each checked frame boundary
//     frame_data    last captured frame, held between pulses
//     frame_err     valid with frame_valid; 1 = frame_data != SYNC
//     word_err_cnt  saturating count of bad frames seen in LOCKED
//     bit_err_cnt   (BIT_ERR_CNT_EN only) saturating count of bad bits in LOCKED
module prbs_frame_checker #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     SYNC      = 8'hA5,
    parameter int unsigned          CONFIRM_N = 2,
    parameter int unsigned          LOSS_THR  = 3,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             signal_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_err_cnt
`ifdef BIT_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] bit_err_cnt
`endif
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned GW = $clog2(CONFIRM_N + 1);
    localparam int unsigned MW = $clog2(LOSS_THR + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_HUNT,
        S_CONFIRM,
        S_LOCKED
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Only the low WIDTH-1 bits of the shifter are ever read back, so the
    // oldest bit is not stored; w_sh_next is the full window for this cycle.
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [BW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_good_cnt;
    logic [GW-1:0]    w_good_inc;
    logic [MW-1:0]    r_miss_cnt;
    logic [MW-1:0]    w_miss_inc;
    logic             w_match;
    logic             w_boundary;
    logic             w_locked_bad;
    logic             w_confirm_done;

    assign w_sh_next      = {r_sh, signal_in};
    assign w_match        = (w_sh_next == SYNC);
    assign w_boundary     = (r_state != S_HUNT) && (r_bit_cnt == BW'(WIDTH - 1));
    assign w_good_inc     = r_good_cnt + GW'(1);
    assign w_miss_inc     = r_miss_cnt + MW'(1);
    assign w_locked_bad   = (r_state == S_LOCKED) && w_boundary && !w_match;
    assign w_confirm_done = (r_state == S_CONFIRM) && w_boundary && w_match &&
                            (w_good_inc == GW'(CONFIRM_N));
    assign locked         = (r_state == S_LOCKED);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_HUNT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_HUNT: begin
                if (w_match) w_state_nxt = S_CONFIRM;
            end
            S_CONFIRM: begin
                // A bad confirm frame drops to HUNT without re-testing the same
                // window for sync; hunting resumes on the next bit.
                if (w_boundary && !w_match) w_state_nxt = S_HUNT;
                else if (w_confirm_done)    w_state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                if (w_locked_bad && (w_miss_inc == MW'(LOSS_THR))) w_state_nxt = S_HUNT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sh        <= '0;
            r_bit_cnt   <= '0;
            r_good_cnt  <= '0;
            r_miss_cnt  <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_err   <= 1'b0;
        end else begin
            r_sh        <= w_sh_next[WIDTH-2:0];
            frame_valid <= w_boundary;
            if (w_boundary) begin
                frame_data <= w_sh_next;
                frame_err  <= !w_match;
            end

            if ((r_state == S_HUNT) && w_match) begin
                r_bit_cnt  <= '0;
                r_good_cnt <= '0;
            end else if (r_state != S_HUNT) begin
                r_bit_cnt <= (r_bit_cnt == BW'(WIDTH - 1)) ? '0 : r_bit_cnt + BW'(1);
                if ((r_state == S_CONFIRM) && w_boundary && w_match)
                    r_good_cnt <= w_good_inc;
            end

            if (w_confirm_done)
                r_miss_cnt <= '0;
            else if ((r_state == S_LOCKED) && w_boundary)
                r_miss_cnt <= w_match ? '0 : w_miss_inc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                 word_err_cnt <= '0;
        else if (clr_cnt)                           word_err_cnt <= '0;
        else if (w_locked_bad && (word_err_cnt != CNT_MAX)) word_err_cnt <= word_err_cnt + CNT_W'(1);
    end

`ifdef BIT_ERR_CNT_EN
    localparam int unsigned PW = $clog2(WIDTH + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    logic [PW-1:0] w_pop;
    logic [SW-1:0] w_bec_sum;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
            w_pop = w_pop + PW'(w_sh_next[i] ^ SYNC[i]);
        w_bec_sum = SW'(bit_err_cnt) + SW'(w_pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)            bit_err_cnt <= '0;
        else if (clr_cnt)      bit_err_cnt <= '0;
        else if (w_locked_bad) bit_err_cnt <= (w_bec_sum > SW'(CNT_MAX)) ? CNT_MAX
                                                                         : w_bec_sum[CNT_W-1:0];
    end
`endif

endmodule

// File: tb/tb_prbs_frame_checker.sv
// Testbench for prbs_frame_checker: a table of frames with expected boundary
// results, driven through a default instance and a CNT_W=2 instance sharing
// the same stimulus, followed by a hand-written mid-frame reset sequence.
module tb_prbs_frame_checker;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig   = 1'b0;
    logic        clr   = 1'b0;

    logic        lk,  fv,  fe;
    logic [7:0]  fd;
    logic [15:0] wec;
    logic        lk2, fv2, fe2;
    logic [7:0]  fd2;
    logic [1:0]  wec2;
`ifdef BIT_ERR_CNT_EN
    logic [15:0] bec;
    logic [1:0]  bec2;
`endif

    prbs_frame_checker u_dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .signal_in    (sig),
        .clr_cnt      (clr),
        .locked       (lk),
        .frame_valid  (fv),
        .frame_data   (fd),
        .frame_err    (fe),
        .word_err_cnt (wec)
`ifdef BIT_ERR_CNT_EN
        ,
        .bit_err_cnt  (bec)
`endif
    );

    prbs_frame_checker #(.CNT_W(2)) u_sat (
        .CLK          (clk),
        .RST_N        (rst_n),
        .signal_in    (sig),
        .clr_cnt      (clr),
        .locked       (lk2),
        .frame_valid  (fv2),
        .frame_data   (fd2),
        .frame_err    (fe2),
        .word_err_cnt (wec2)
`ifdef BIT_ERR_CNT_EN
        ,
        .bit_err_cnt  (bec2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  frame;
        logic        clr;
        logic        valid;
        logic [7:0]  data;
        logic        err;
        logic        lock;
        logic [15:0] wec;
        logic [1:0]  wec2;
        logic [15:0] bec;
        logic [1:0]  bec2;
    } vec_t;

    localparam int NV = 18;
    vec_t vec[NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic c);
        sig = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          frame  clr valid data   err lock wec    wec2  bec    bec2
        vec[0]  = '{8'hA5, 0,  0,    8'h00, 0,  0,   16'd0, 2'd0, 16'd0,  2'd0};
        vec[1]  = '{8'hA5, 0,  1,    8'hA5, 0,  0,   16'd0, 2'd0, 16'd0,  2'd0};
        vec[2]  = '{8'hA5, 0,  1,    8'hA5, 0,  1,   16'd0, 2'd0, 16'd0,  2'd0};
        vec[3]  = '{8'hA4, 0,  1,    8'hA4, 1,  1,   16'd1, 2'd1, 16'd1,  2'd1};
        vec[4]  = '{8'hA5, 0,  1,    8'hA5, 0,  1,   16'd1, 2'd1, 16'd1,  2'd1};
        vec[5]  = '{8'h00, 0,  1,    8'h00, 1,  1,   16'd2, 2'd2, 16'd5,  2'd3};
        vec[6]  = '{8'h00, 0,  1,    8'h00, 1,  1,   16'd3, 2'd3, 16'd9,  2'd3};
        vec[7]  = '{8'h00, 0,  1,    8'h00, 1,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[8]  = '{8'h00, 0,  0,    8'h00, 0,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[9]  = '{8'hA5, 0,  0,    8'h00, 0,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[10] = '{8'h00, 0,  1,    8'h00, 1,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[11] = '{8'hA5, 0,  0,    8'h00, 0,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[12] = '{8'hA5, 0,  1,    8'hA5, 0,  0,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[13] = '{8'hA5, 0,  1,    8'hA5, 0,  1,   16'd4, 2'd3, 16'd13, 2'd3};
        vec[14] = '{8'h00, 1,  1,    8'h00, 1,  1,   16'd0, 2'd0, 16'd0,  2'd0};
        vec[15] = '{8'hA5, 0,  1,    8'hA5, 0,  1,   16'd0, 2'd0, 16'd0,  2'd0};
        vec[16] = '{8'h00, 0,  1,    8'h00, 1,  1,   16'd1, 2'd1, 16'd4,  2'd3};
        vec[17] = '{8'hA5, 0,  1,    8'hA5, 0,  1,   16'd1, 2'd1, 16'd4,  2'd3};

        // Reset state
        #1;
        check("rst_locked", {31'd0, lk}, 32'd0);
        check("rst_valid",  {31'd0, fv}, 32'd0);
        check("rst_err",    {31'd0, fe}, 32'd0);
        check("rst_data",   {24'd0, fd}, 32'd0);
        check("rst_wec",    {16'd0, wec}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(vec[r].frame[i], (i == 0) ? vec[r].clr : 1'b0);
                if (i != 0) begin
                    check($sformatf("r%0d_b%0d_valid", r, i), {31'd0, fv}, 32'd0);
                end else begin
                    check($sformatf("r%0d_valid", r),  {31'd0, fv},   {31'd0, vec[r].valid});
                    check($sformatf("r%0d_data", r),   {24'd0, fd},   {24'd0, vec[r].data});
                    if (vec[r].valid)
                        check($sformatf("r%0d_err", r), {31'd0, fe},  {31'd0, vec[r].err});
                    check($sformatf("r%0d_locked", r), {31'd0, lk},   {31'd0, vec[r].lock});
                    check($sformatf("r%0d_locked2", r),{31'd0, lk2},  {31'd0, vec[r].lock});
                    check($sformatf("r%0d_wec", r),    {16'd0, wec},  {16'd0, vec[r].wec});
                    check($sformatf("r%0d_wec2", r),   {30'd0, wec2}, {30'd0, vec[r].wec2});
`ifdef BIT_ERR_CNT_EN
                    check($sformatf("r%0d_bec", r),    {16'd0, bec},  {16'd0, vec[r].bec});
                    check($sformatf("r%0d_bec2", r),   {30'd0, bec2}, {30'd0, vec[r].bec2});
`endif
                end
            end
        end
        clr = 1'b0;

        // Mid-frame asynchronous reset while locked: three bits into an A5 frame
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_locked", {31'd0, lk},  32'd0);
        check("mrst_valid",  {31'd0, fv},  32'd0);
        check("mrst_wec",    {16'd0, wec}, 32'd0);
        check("mrst_data",   {24'd0, fd},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mrst_hold_locked", {31'd0, lk}, 32'd0);
        rst_n = 1'b1;

        // Relock needs sync frame plus CONFIRM_N checked frames
        for (int f = 0; f < 3; f++) begin
            logic [7:0] w;
            w = 8'hA5;
            for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
            check($sformatf("relock_f%0d_valid", f),  {31'd0, fv}, (f == 0) ? 32'd0 : 32'd1);
            check($sformatf("relock_f%0d_locked", f), {31'd0, lk}, (f == 2) ? 32'd1 : 32'd0);
        end
        check("relock_wec", {16'd0, wec}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
